// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants for the UART TX feeder: FSM encoding, default widths and
// the pointer-width helper.
package uart_tx_feeder_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_WAIT_FALL = 2'd2;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_RISE = ST_WAIT_RISE,
    S_WAIT_FALL = ST_WAIT_FALL
  } fsm_state_t;

  // Bits needed to address 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Write-side and transmitter-side signals of the feeder. The master side is
// the system controller plus the transmitter's busy flag; the slave side is
// the feeder itself.
interface uart_tx_feeder_if
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8
);
  localparam int CW = clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  tx_busy;
  logic                  tx_timeout;

  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_data_valid, tx_timeout
  );

  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, count, overflow, tx_data, tx_data_valid, tx_timeout
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the TX sequencer. Occupancy lives in a
// registered count; FULL/EMPTY derive from it so the pointers can wrap freely.
module uart_tx_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_en,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO rejects writes even when a pop frees a slot on the same edge.
  assign wr_acc  = wr_en & ~full;
  assign rd_acc  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Pops bytes from the FIFO and hands them to the UART transmitter with a
// one-cycle valid pulse, then waits for TX_BUSY to rise and fall. If busy
// never rises within TIMEOUT cycles the byte is abandoned.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_feeder_if.slave  bus
);
  // Counter saturates at TIMEOUT-1; the edge that would reach TIMEOUT fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fsm_state_t            state;
  logic [7:0]            tcnt;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;

  // Issue only from IDLE with data waiting and the transmitter free.
  assign pop = (state == S_IDLE) && !bus.empty && !bus.tx_busy;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (bus.wr_data),
    .wr_en    (bus.wr_en),
    .pop      (pop),
    .rd_data  (head),
    .full     (bus.full),
    .empty    (bus.empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  // Handshake sequencer with registered outputs and the rise timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      tcnt              <= '0;
      bus.tx_data       <= '0;
      bus.tx_data_valid <= 1'b0;
      bus.tx_timeout    <= 1'b0;
    end else begin
      bus.tx_data_valid <= 1'b0;
      bus.tx_timeout    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            bus.tx_data       <= head;
            bus.tx_data_valid <= 1'b1;
            tcnt              <= '0;
            state             <= S_WAIT_RISE;
          end
        end
        S_WAIT_RISE: begin
          if (bus.tx_busy) begin
            state <= S_WAIT_FALL;
          end else if (tcnt == TO_LAST) begin
            // Byte is dropped, not re-queued.
            bus.tx_timeout <= 1'b1;
            state          <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WAIT_FALL: begin
          if (!bus.tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (DATA_WIDTH=8, DEPTH=8, TIMEOUT=16).
module tb_uart_tx_feeder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [7:0] got[$];
  logic [7:0] sb[$];

  uart_tx_feeder_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_count;
    logic       e_empty;
    logic       e_ovf;
    logic       e_to;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one edge, sample 1 ns later.
  task automatic step(input logic we, input logic [7:0] d, input logic busy);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.tx_busy = busy;
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy for 3 edges after each valid pulse. Collects
  // issued bytes into 'got' and runs a few cycles past the n-th byte so a
  // spurious extra pulse would show up in the count.
  task automatic run_xmit(input int n, input int init_hold, input int budget);
    int hold;
    int tail;
    hold = init_hold;
    tail = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      bus.tx_busy = (hold > 0);
      if (hold > 0) hold--;
      bus.wr_en = 1'b0;
      @(posedge clk);
      #1;
      if (bus.tx_data_valid) begin
        got.push_back(bus.tx_data);
        hold = 3;
      end
      if (got.size() >= n) tail++;
      if (tail > 6) break;
    end
    chk("xmit.nbytes", got.size(), n);
  endtask

  initial begin
    int first_to;
    int bad_cnt;
    checks   = 0;
    failures = 0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_busy = 1'b0;
    rst_n       = 1'b0;

    // Test 2 vectors: write A5, one pulse two edges later, busy later.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0};
    for (int i = 4; i < 14; i++)
      vecs[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b1, 1'b0, 1'b0};

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.count", bus.count, 0);
    chk("rst.empty", bus.empty, 1);
    chk("rst.full", bus.full, 0);
    chk("rst.tx_data", bus.tx_data, 0);
    chk("rst.valid", bus.tx_data_valid, 0);
    chk("rst.ovf", bus.overflow, 0);
    chk("rst.timeout", bus.tx_timeout, 0);
    rst_n = 1'b1;

    // Test 2 via the table.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].wr_en, vecs[i].wr_data, vecs[i].busy);
      chk($sformatf("t2[%0d].valid", i), bus.tx_data_valid, vecs[i].e_valid);
      chk($sformatf("t2[%0d].data", i), bus.tx_data, vecs[i].e_data);
      chk($sformatf("t2[%0d].count", i), bus.count, vecs[i].e_count);
      chk($sformatf("t2[%0d].empty", i), bus.empty, vecs[i].e_empty);
      chk($sformatf("t2[%0d].ovf", i), bus.overflow, vecs[i].e_ovf);
      chk($sformatf("t2[%0d].to", i), bus.tx_timeout, vecs[i].e_to);
    end

    // Test 1: reset while in WAIT_FALL with 3 bytes queued.
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1.issue", bus.tx_data_valid, 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    step(1'b1, 8'h44, 1'b1);
    chk("t1.queued", bus.count, 3);
    bus.wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t1.rst.count", bus.count, 0);
    chk("t1.rst.empty", bus.empty, 1);
    chk("t1.rst.tx_data", bus.tx_data, 0);
    bus.tx_busy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("t1.post[%0d].valid", i), bus.tx_data_valid, 0);
      chk($sformatf("t1.post[%0d].empty", i), bus.empty, 1);
    end

    // Test 3: fill to FULL, overflow on the 9th, drain in order.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk($sformatf("t3.fill[%0d].count", i), bus.count, i);
    end
    chk("t3.full", bus.full, 1);
    step(1'b1, 8'h09, 1'b1);
    chk("t3.ovf", bus.overflow, 1);
    chk("t3.ovf.count", bus.count, 8);
    step(1'b0, 8'h00, 1'b1);
    chk("t3.ovf.clear", bus.overflow, 0);
    got.delete();
    run_xmit(8, 0, 200);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("t3.order[%0d]", i), got[i], 8'(i + 1));
    chk("t3.empty", bus.empty, 1);

    // Test 4: full, pop and write on the same edge.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b1);
    chk("t4.full", bus.full, 1);
    step(1'b1, 8'h55, 1'b0);
    chk("t4.ovf", bus.overflow, 1);
    chk("t4.count", bus.count, 7);
    chk("t4.valid", bus.tx_data_valid, 1);
    chk("t4.data", bus.tx_data, 8'h10);
    got.delete();
    run_xmit(7, 3, 200);
    for (int i = 0; i < 7 && i < got.size(); i++)
      chk($sformatf("t4.order[%0d]", i), got[i], 8'h11 + 8'(i));
    chk("t4.empty", bus.empty, 1);

    // Test 5: rise timeout, then the next byte goes out.
    step(1'b1, 8'h3C, 1'b1);
    step(1'b1, 8'h3D, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t5.issue", bus.tx_data, 8'h3C);
    first_to = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (bus.tx_timeout && first_to == 0) first_to = k;
    end
    chk("t5.timeout_cycle", first_to, 16);
    step(1'b0, 8'h00, 1'b0);
    chk("t5.to.pulse_width", bus.tx_timeout, 0);
    chk("t5.next.valid", bus.tx_data_valid, 1);
    chk("t5.next.data", bus.tx_data, 8'h3D);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Test 6: write on every issue edge at COUNT=4; scoreboard data.
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hC0 + 8'(i), 1'b1);
      sb.push_back(8'hC0 + 8'(i));
    end
    chk("t6.prefill", bus.count, 4);
    bad_cnt = 0;
    for (int b = 0; b < 100; b++) begin
      for (int ph = 0; ph < 5; ph++) begin
        if (ph == 0) begin
          step(1'b1, 8'(b * 7 + 3), 1'b0);
          sb.push_back(8'(b * 7 + 3));
          chk($sformatf("t6[%0d].valid", b), bus.tx_data_valid, 1);
          chk($sformatf("t6[%0d].data", b), bus.tx_data, sb.pop_front());
        end else begin
          step(1'b0, 8'h00, (ph != 4));
          if (bus.tx_data_valid) bad_cnt++;
        end
        if (bus.count != 4) bad_cnt++;
      end
    end
    chk("t6.count_or_extra_pulses", bad_cnt, 0);
    chk("t6.final_count", bus.count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
